// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the multi-cycle data-memory responder: FSM states,
// captured operation type and the latency ceiling set by the 4-bit counter.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int MAX_LAT = 15;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with a registered read port and no reset, so the
// contents survive a controller reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder: captures one request in IDLE, counts out LAT
// cycles in WAIT, performs the access on the WAIT->DONE edge, releases in DONE.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_read,
  input  logic        req_write,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        err
);

  if (LAT < 1 || LAT > MAX_LAT) begin : g_bad_lat
    $error("dmem_responder: LAT must be within 1..15");
  end
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("dmem_responder: DEPTH must equal 2**AW");
  end

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  // Handshake: the core holds req_* steady while stall is high; the request
  // is accepted in IDLE and the core advances at the end of the DONE cycle.
  state_t          state;
  state_t          state_nx;
  logic [3:0]      cnt;
  logic [AW+1:0]   addr;
  logic [31:0]     wdata;
  op_t             op;
  logic            both_ops;

  logic            req;
  logic            misaligned;
  logic            finish;
  logic            arr_we;
  logic [AW-1:0]   arr_idx;
  logic [31:0]     arr_rdata;
  logic            unused_addr;

  assign req         = req_read | req_write;
  assign misaligned  = (addr[1:0] != 2'b00);
  assign finish      = (state == WAIT) && (cnt == 4'd0);
  assign arr_we      = finish && (op == OP_WR) && !misaligned;
  assign unused_addr = ^req_addr[31:AW+2];

  // In IDLE the RAM already reads the incoming index, so its registered
  // output holds the target word by the time the countdown expires.
  assign arr_idx = (state == IDLE) ? req_addr[AW+1:2] : addr[AW+1:2];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nx = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr     <= '0;
      wdata    <= 32'd0;
      op       <= OP_RD;
      both_ops <= 1'b0;
      rdata    <= 32'd0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nx;
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (state == IDLE && req) begin
        addr     <= req_addr[AW+1:0];
        wdata    <= req_wdata;
        op       <= req_write ? OP_WR : OP_RD;
        both_ops <= req_read & req_write;
        cnt      <= LAT_M1;
      end else if (state == WAIT) begin
        if (cnt == 4'd0) begin
          err <= both_ops | misaligned;
          if (op == OP_RD) begin
            rvalid <= 1'b1;
            rdata  <= misaligned ? 32'd0 : arr_rdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT=2, 1, 15) driven through a
// per-access task, with a reference word model and an expected-load queue.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_read  [3];
  logic        req_write [3];
  logic [31:0] rdata     [3];
  logic        rvalid    [3];
  logic        stall     [3];
  logic        err       [3];

  logic [31:0] model [3][256];
  logic [31:0] exp_q [$];
  int          total;
  int          bad;

  dmem_responder #(.DEPTH(256), .AW(8), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_read(req_read[0]), .req_write(req_write[0]), .rdata(rdata[0]),
    .rvalid(rvalid[0]), .stall(stall[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH(256), .AW(8), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_read(req_read[1]), .req_write(req_write[1]), .rdata(rdata[1]),
    .rvalid(rvalid[1]), .stall(stall[1]), .err(err[1])
  );

  dmem_responder #(.DEPTH(256), .AW(8), .LAT(15)) u_lat15 (
    .clk(clk), .rst(rst), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_read(req_read[2]), .req_write(req_write[2]), .rdata(rdata[2]),
    .rvalid(rvalid[2]), .stall(stall[2]), .err(err[2])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1);
  end

  // driver: one full access on instance s, checked against the model.
  task automatic access(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input string name);
    int          n;
    logic        aligned;
    logic        exp_err;
    logic        exp_valid;
    logic [7:0]  ix;
    logic [31:0] exp_data;
    aligned   = (a[1:0] == 2'b00);
    exp_err   = !aligned || (rd && wr);
    exp_valid = rd && !wr;
    ix        = a[9:2];
    @(negedge clk);
    req_addr[s]  = a;
    req_wdata[s] = wd;
    req_read[s]  = rd;
    req_write[s] = wr;
    if (exp_valid) exp_q.push_back(aligned ? model[s][ix] : 32'd0);
    if (wr && aligned) model[s][ix] = wd;
    #1;
    n = 0;
    while (stall[s] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    total++;
    if (n !== lat + 1) begin
      bad++;
      $display("FAIL %s stall_len: actual=%0d required=%0d", name, n, lat + 1);
    end
    total++;
    if (err[s] !== exp_err) begin
      bad++;
      $display("FAIL %s err_done: actual=%b required=%b", name, err[s], exp_err);
    end
    total++;
    if (rvalid[s] !== exp_valid) begin
      bad++;
      $display("FAIL %s rvalid_done: actual=%b required=%b", name, rvalid[s], exp_valid);
    end
    if (rvalid[s] === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s rdata: actual=%h required=<no pending load>", name, rdata[s]);
      end else begin
        exp_data = exp_q.pop_front();
        if (rdata[s] !== exp_data) begin
          bad++;
          $display("FAIL %s rdata: actual=%h required=%h", name, rdata[s], exp_data);
        end
      end
    end
    req_read[s]  = 1'b0;
    req_write[s] = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (err[s] !== 1'b0 || rvalid[s] !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse_after_done: actual err=%b rvalid=%b required err=0 rvalid=0",
               name, err[s], rvalid[s]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (stall[s] !== 1'b0 || rvalid[s] !== 1'b0 || err[s] !== 1'b0 || rdata[s] !== 32'd0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: actual stall=%b rvalid=%b err=%b rdata=%h required 0/0/0/0",
                 s, stall[s], rvalid[s], err[s], rdata[s]);
      end
    end
    total++;
    if (u_lat2.state !== IDLE || u_lat1.state !== IDLE || u_lat15.state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: actual=%0d/%0d/%0d required=0/0/0",
               u_lat2.state, u_lat1.state, u_lat15.state);
    end
  endtask

  task automatic test_store_load(input int s, input int lat);
    string tag;
    tag = $sformatf("store_load_lat%0d", lat);
    access(s, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, {tag, "_st"});
    access(s, 1'b1, 1'b0, 32'h10, 32'h0,        lat, {tag, "_ld"});
  endtask

  task automatic test_misaligned();
    access(0, 1'b1, 1'b0, 32'h13, 32'h0,        2, "misaligned_ld");
    access(0, 1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 2, "misaligned_st");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0,        2, "misaligned_noch");
  endtask

  task automatic test_wrap();
    access(0, 1'b0, 1'b1, 32'h400, 32'h1234, 2, "wrap_st");
    access(0, 1'b1, 1'b0, 32'h000, 32'h0,    2, "wrap_ld");
  endtask

  task automatic test_read_write_both();
    access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 2, "both_st");
    access(0, 1'b1, 1'b0, 32'h20, 32'h0,        2, "both_ld");
  endtask

  task automatic test_reset_mid();
    access(0, 1'b0, 1'b1, 32'h30, 32'h1111, 2, "rstmid_pre");
    @(negedge clk);
    req_addr[0]  = 32'h30;
    req_wdata[0] = 32'h5555;
    req_write[0] = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (u_lat2.state !== WAIT) begin
      bad++;
      $display("FAIL rstmid_in_wait: actual=%0d required=%0d", u_lat2.state, WAIT);
    end
    rst          = 1'b1;
    req_write[0] = 1'b0;
    #1;
    total++;
    if (u_lat2.state !== IDLE || stall[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort: actual state=%0d stall=%b required state=0 stall=0",
               u_lat2.state, stall[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 2, "rstmid_ld");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] keep;
    for (int i = 0; i < 12; i++) begin
      a = {22'd0, 6'($urandom_range(32, 63)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        access(0, 1'b0, 1'b1, a, $urandom, 2, $sformatf("b2b_st%0d", i));
      else
        access(0, 1'b1, 1'b0, a, 32'h0, 2, $sformatf("b2b_ld%0d", i));
    end
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 2, "hold_ld");
    keep = model[0][8'h08];
    access(0, 1'b0, 1'b1, 32'h24, 32'h77, 2, "hold_st");
    total++;
    if (rdata[0] !== keep) begin
      bad++;
      $display("FAIL rdata_hold: actual=%h required=%h", rdata[0], keep);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int s = 0; s < 3; s++) begin
      req_addr[s]  = 32'd0;
      req_wdata[s] = 32'd0;
      req_read[s]  = 1'b0;
      req_write[s] = 1'b0;
      for (int i = 0; i < 256; i++) model[s][i] = 32'd0;
    end
    rst = 1'b1;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_store_load(0, 2);
    test_store_load(1, 1);
    test_store_load(2, 15);
    test_misaligned();
    test_wrap();
    test_read_write_both();
    test_reset_mid();
    test_back_to_back();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_loads: actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
